// File: rtl/status_flag_controller.sv
// Status flag controller: sequences one ALU micro-op at a time and
// commits masked {V,Z,S,C} flags plus the result word on completion.
module status_flag_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_mask,
    output logic       alu_start,
    input  logic       alu_done,
    input  logic [3:0] word_out,
    input  logic       flag_v,
    input  logic       flag_z,
    input  logic       flag_s,
    input  logic       flag_c,
    output logic [3:0] flags,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       timeout_err,
    input  logic       flag_clr,
    input  logic [2:0] cond_sel,
    output logic       cond_true
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Last count value before the wait budget is exhausted.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] mask_q;
    logic [3:0] flag_in;

    assign flag_in = {flag_v, flag_z, flag_s, flag_c};

    // Operation sequencer with registered handshake, strobe and commit state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            mask_q       <= '0;
            flags        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            alu_start    <= 1'b0;
            op_ready     <= 1'b1;
            timeout_err  <= 1'b0;
        end else begin
            alu_start    <= 1'b0;
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (flag_clr) begin
                        flags       <= '0;
                        timeout_err <= 1'b0;
                    end
                    if (op_valid) begin
                        mask_q    <= op_mask;
                        state     <= ISSUE;
                        op_ready  <= 1'b0;
                        alu_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completing ALU beats the timeout on the same edge.
                    if (alu_done) begin
                        result       <= word_out;
                        flags        <= (flags & ~mask_q) | (flag_in & mask_q);
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

    // Branch condition evaluated on the committed flags {V,Z,S,C}.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond_sel)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags[2];
            3'b010:  cond_true = ~flags[2];
            3'b011:  cond_true = flags[0];
            3'b100:  cond_true = ~flags[0];
            3'b101:  cond_true = flags[1];
            3'b110:  cond_true = flags[3];
            3'b111:  cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_status_flag_controller.sv
// Bench for status_flag_controller: directed and randomized ops
// compared against a transaction-level flag/result model.
module tb_status_flag_controller;

    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_mask;
    logic       alu_start;
    logic       alu_done;
    logic [3:0] word_out;
    logic       flag_v, flag_z, flag_s, flag_c;
    logic [3:0] flags;
    logic [3:0] result;
    logic       result_valid;
    logic       timeout_err;
    logic       flag_clr;
    logic [2:0] cond_sel;
    logic       cond_true;

    int checks = 0;
    int failures = 0;

    logic [3:0] m_flags;
    logic [3:0] m_result;
    logic       m_terr;

    status_flag_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_mask(op_mask),
        .alu_start(alu_start), .alu_done(alu_done), .word_out(word_out),
        .flag_v(flag_v), .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c),
        .flags(flags), .result(result), .result_valid(result_valid),
        .timeout_err(timeout_err), .flag_clr(flag_clr),
        .cond_sel(cond_sel), .cond_true(cond_true)
    );

    always #20 clk = ~clk;

    task automatic check4(input string tag, input logic [3:0] obs,
                          input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Condition table indexed by cond_sel, built from {V,Z,S,C}.
    function automatic logic m_cond(input logic [2:0] sel, input logic [3:0] f);
        logic [7:0] tbl;
        tbl = {1'b0, f[3], f[1], ~f[0], f[0], ~f[2], f[2], 1'b1};
        return tbl[sel];
    endfunction

    task automatic drive_flags(input logic [3:0] f);
        {flag_v, flag_z, flag_s, flag_c} = f;
    endtask

    task automatic check_conds();
        for (int i = 0; i < 8; i++) begin
            cond_sel = 3'(i);
            #1;
            check1("cond_true", cond_true, m_cond(3'(i), m_flags));
        end
    endtask

    task automatic check_state(input string tag);
        check4({tag, "_flags"}, flags, m_flags);
        check4({tag, "_result"}, result, m_result);
        check1({tag, "_terr"}, timeout_err, m_terr);
    endtask

    // One op; alu_done lands in WAIT cycle 'delay' (beyond TO -> timeout).
    task automatic do_op(input logic [3:0] mask, input int delay,
                         input logic [3:0] word, input logic [3:0] fin,
                         input logic clr);
        logic cap;
        cap = 1'b0;
        @(negedge clk);
        check1("ready_idle", op_ready, 1'b1);
        op_valid = 1'b1;
        op_mask  = mask;
        flag_clr = clr;
        alu_done = 1'($urandom_range(0, 1));
        word_out = 4'($urandom_range(0, 15));
        drive_flags(4'($urandom_range(0, 15)));
        @(negedge clk);
        if (clr) begin
            m_flags = 4'h0;
            m_terr  = 1'b0;
        end
        check1("alu_start_issue", alu_start, 1'b1);
        check1("ready_busy", op_ready, 1'b0);
        check_state("issue");
        op_valid = 1'($urandom_range(0, 1));
        op_mask  = 4'($urandom_range(0, 15));
        flag_clr = 1'($urandom_range(0, 1));
        alu_done = 1'($urandom_range(0, 1));
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            check1("alu_start_wait", alu_start, 1'b0);
            check1("rv_wait", result_valid, 1'b0);
            alu_done = (k == delay);
            word_out = word;
            drive_flags(fin);
            if (k == delay) begin
                cap = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (cap) begin
            m_flags  = (m_flags & ~mask) | (fin & mask);
            m_result = word;
        end else begin
            m_terr = 1'b1;
        end
        check1("rv_done", result_valid, cap);
        check_state("done");
        op_valid = 1'b0;
        flag_clr = 1'b0;
        alu_done = 1'($urandom_range(0, 1));
        drive_flags(4'($urandom_range(0, 15)));
        @(negedge clk);
        alu_done = 1'b0;
        check1("ready_back", op_ready, 1'b1);
        check1("rv_idle", result_valid, 1'b0);
        check_state("idle");
        check_conds();
    endtask

    initial begin
        int last;
        int npulse;
        int nrv;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_mask  = 4'h0;
        alu_done = 1'b0;
        word_out = 4'h0;
        flag_clr = 1'b0;
        cond_sel = 3'b000;
        drive_flags(4'h0);
        m_flags  = 4'h0;
        m_result = 4'h0;
        m_terr   = 1'b0;

        repeat (2) @(negedge clk);
        check_state("reset");
        check1("reset_rv", result_valid, 1'b0);
        check1("reset_start", alu_start, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check1("ready_after_reset", op_ready, 1'b1);

        do_op(4'hF, 2, 4'h0, 4'b0101, 1'b0);
        check4("basic_flags", flags, 4'b0101);
        do_op(4'hF, 1, 4'h9, 4'hF, 1'b0);
        do_op(4'b0100, 1, 4'h3, 4'h0, 1'b0);
        check4("s_only_flags", flags, 4'b1011);
        do_op(4'hF, 5, 4'h7, 4'h0, 1'b0);
        check1("timeout_set", timeout_err, 1'b1);
        do_op(4'hA, 2, 4'h2, 4'h0, 1'b0);
        check1("timeout_sticky", timeout_err, 1'b1);
        do_op(4'hF, TO, 4'h6, 4'b1010, 1'b1);
        check1("edge_capture_no_to", timeout_err, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_op(4'($urandom_range(0, 15)), int'($urandom_range(1, 5)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0));
        end

        // Continuous op_valid with flag_clr held and instant alu_done.
        @(negedge clk);
        op_valid = 1'b1;
        flag_clr = 1'b1;
        op_mask  = 4'b0011;
        alu_done = 1'b1;
        word_out = 4'hC;
        drive_flags(4'b0001);
        last   = -1;
        npulse = 0;
        nrv    = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (alu_start) begin
                if (last >= 0) begin
                    check4("b2b_spacing", 4'(c - last), 4'd4);
                end
                check4("b2b_clr_flags", flags, 4'h0);
                check1("b2b_clr_terr", timeout_err, 1'b0);
                last = c;
                npulse++;
            end
            if (result_valid) nrv++;
        end
        check4("b2b_pulses", 4'(npulse), 4'd5);
        check4("b2b_results", 4'(nrv), 4'd5);
        op_valid = 1'b0;
        flag_clr = 1'b0;
        alu_done = 1'b0;
        m_flags  = 4'b0001;
        m_result = 4'hC;
        m_terr   = 1'b0;
        @(negedge clk);
        check1("b2b_ready", op_ready, 1'b1);
        check_state("b2b");

        // Reset while waiting on the ALU, then a stray alu_done.
        op_valid = 1'b1;
        op_mask  = 4'hF;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_flags  = 4'h0;
        m_result = 4'h0;
        m_terr   = 1'b0;
        check_state("async_rst");
        check1("async_rst_ready", op_ready, 1'b1);
        check1("async_rst_start", alu_start, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        alu_done = 1'b1;
        word_out = 4'hF;
        drive_flags(4'hF);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check1("post_rst_rv", result_valid, 1'b0);
            check1("post_rst_ready", op_ready, 1'b1);
            check_state("post_rst");
        end
        alu_done = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
